// File: rtl/turn_sequencer.sv
// Board-state sequencer for the memory-card game: face-up/matched masks, turn owner, reveal hold, end of game.
// Optional TURN_TIMEOUT_EN adds an idle-turn forfeit counter.
module turn_sequencer #(
  parameter int CARDS          = 16,
  parameter int REVEAL_CYCLES  = 25000000,
  parameter int TIMEOUT_CYCLES = 250000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             select,
  input  logic [3:0]       cursor,
  input  logic [1:0]       x,
  input  logic             par,
  input  logic [7:0]       selected1,
  input  logic [7:0]       selected2,
  output logic             player,
  output logic             empty,
  output logic [CARDS-1:0] face_up,
  output logic [CARDS-1:0] matched,
  output logic             busy,
  output logic             game_over,
  output logic             tie,
  output logic             timeout
);

  localparam int RW = (REVEAL_CYCLES > 1) ? $clog2(REVEAL_CYCLES) : 1;

  typedef enum logic [1:0] {
    PLAY   = 2'd0,
    REVEAL = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             player_q, player_d;
  logic             tie_q, tie_d;
  logic [CARDS-1:0] face_q, face_d;
  logic [CARDS-1:0] match_q, match_d;
  logic [RW-1:0]    rcnt_q, rcnt_d;
  logic [1:0]       xprev_q;

  logic [CARDS-1:0] cur_m, s1_m, s2_m;
  logic             eval_ev, end_ev, empty_w;

  // One-hot masks; out-of-range indices give an all-zero mask.
  always_comb begin
    cur_m = '0;
    s1_m  = '0;
    s2_m  = '0;
    for (int unsigned i = 0; i < CARDS; i++) begin
      cur_m[i] = (32'(cursor) == i);
      s1_m[i]  = (32'(selected1) == i);
      s2_m[i]  = (32'(selected2) == i);
    end
  end

  assign eval_ev = (x == 2'b01) && (xprev_q != 2'b01);
  assign end_ev  = x[1];
  assign empty_w = (state_q == PLAY) && |(cur_m & ~face_q & ~match_q);

`ifdef TURN_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TW-1:0] idle_q, idle_d;
  logic          tout_q, tout_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PLAY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      PLAY: begin
        if (end_ev)
          state_d = DONE;
        else if (eval_ev && !par)
          state_d = REVEAL;
      end
      REVEAL: begin
        if (end_ev)
          state_d = DONE;
        else if (rcnt_q == '0)
          state_d = PLAY;
      end
      DONE:    state_d = DONE;
      default: state_d = PLAY;
    endcase
  end

  always_comb begin
    player_d = player_q;
    tie_d    = tie_q;
    face_d   = face_q;
    match_d  = match_q;
    rcnt_d   = rcnt_q;
    unique case (state_q)
      PLAY: begin
        if (end_ev) begin
          tie_d = x[0];
        end else if (eval_ev) begin
          if (par) begin
            match_d = match_q | s1_m | s2_m;
            face_d  = face_q & ~(s1_m | s2_m);
          end else begin
            rcnt_d = RW'(REVEAL_CYCLES - 1);
          end
        end else if (select && empty_w) begin
          face_d = face_q | cur_m;
        end
      end
      REVEAL: begin
        if (end_ev) begin
          tie_d = x[0];
        end else if (rcnt_q == '0) begin
          face_d   = '0;
          player_d = ~player_q;
        end else begin
          rcnt_d = rcnt_q - 1'b1;
        end
      end
      default: ;
    endcase
`ifdef TURN_TIMEOUT_EN
    idle_d = idle_q;
    tout_d = 1'b0;
    if (state_q == PLAY && !end_ev) begin
      if (eval_ev || select) begin
        idle_d = '0;
      end else if (idle_q == TW'(TIMEOUT_CYCLES - 1)) begin
        idle_d   = '0;
        tout_d   = 1'b1;
        face_d   = '0;
        player_d = ~player_q;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end else if (state_q == REVEAL && !end_ev && rcnt_q == '0) begin
      idle_d = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      player_q <= 1'b0;
      tie_q    <= 1'b0;
      face_q   <= '0;
      match_q  <= '0;
      rcnt_q   <= '0;
      xprev_q  <= 2'b00;
    end else begin
      player_q <= player_d;
      tie_q    <= tie_d;
      face_q   <= face_d;
      match_q  <= match_d;
      rcnt_q   <= rcnt_d;
      xprev_q  <= x;
    end
  end

`ifdef TURN_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_q <= '0;
      tout_q <= 1'b0;
    end else begin
      idle_q <= idle_d;
      tout_q <= tout_d;
    end
  end

  assign timeout = tout_q;
`else
  assign timeout = 1'b0;
`endif

  assign player    = player_q;
  assign empty     = empty_w;
  assign face_up   = face_q;
  assign matched   = match_q;
  assign busy      = (state_q == REVEAL);
  assign game_over = (state_q == DONE);
  assign tie       = tie_q;

endmodule

// File: tb/tb_turn_sequencer.sv
// Directed scoreboard bench for turn_sequencer (REVEAL_CYCLES=4, TIMEOUT_CYCLES=8).
// Build with TURN_TIMEOUT_EN defined to exercise the idle forfeit.
module tb_turn_sequencer;

  logic        clk = 1'b0;
  logic        rst, select, par;
  logic [3:0]  cursor;
  logic [1:0]  x;
  logic [7:0]  selected1, selected2;
  logic        player, empty, busy, game_over, tie, timeout;
  logic [15:0] face_up, matched;

  typedef struct {
    string       tag;
    logic [37:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  turn_sequencer #(
    .CARDS(16),
    .REVEAL_CYCLES(4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .select(select),
    .cursor(cursor),
    .x(x),
    .par(par),
    .selected1(selected1),
    .selected2(selected2),
    .player(player),
    .empty(empty),
    .face_up(face_up),
    .matched(matched),
    .busy(busy),
    .game_over(game_over),
    .tie(tie),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Expected vector: {player,busy,game_over,tie,empty,timeout,face_up,matched}
  task automatic step(
    input string       tag,
    input logic        r, s,
    input logic [3:0]  c,
    input logic [1:0]  xv,
    input logic        pr,
    input logic [7:0]  a, b,
    input logic        ep, eb, eg, et, ee, eto,
    input logic [15:0] efu, em
  );
    exp_t e, o;
    logic [37:0] got;
    rst       = r;
    select    = s;
    cursor    = c;
    x         = xv;
    par       = pr;
    selected1 = a;
    selected2 = b;
    e.tag = tag;
    e.v   = {ep, eb, eg, et, ee, eto, efu, em};
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    o   = exp_q.pop_front();
    got = {player, busy, game_over, tie, empty, timeout, face_up, matched};
    n_checks++;
    assert (got === o.v)
    else begin
      n_fail++;
      $error("FAIL %s got=%h exp=%h", o.tag, got, o.v);
    end
  endtask

  initial begin
    logic [15:0] tfu;
    logic        tp, tto;
    rst = 1'b1; select = 1'b0; cursor = 4'd3; x = 2'b00;
    par = 1'b0; selected1 = 8'd0; selected2 = 8'd0;

    //   tag        r  s  cur  x     par a   b    p  b  g  t  e  to fu        m
    step("rst0",    1, 0, 3, 2'b00, 0, 0, 0,    0, 0, 0, 0, 1, 0, 16'h0000, 16'h0000);
    step("rst1",    1, 0, 3, 2'b00, 0, 0, 0,    0, 0, 0, 0, 1, 0, 16'h0000, 16'h0000);
    step("pick2",   0, 1, 2, 2'b00, 0, 0, 0,    0, 0, 0, 0, 0, 0, 16'h0004, 16'h0000);
    step("pick7",   0, 1, 7, 2'b00, 0, 0, 0,    0, 0, 0, 0, 0, 0, 16'h0084, 16'h0000);
    step("match27", 0, 0, 2, 2'b01, 1, 2, 7,    0, 0, 0, 0, 0, 0, 16'h0000, 16'h0084);
    step("idle0",   0, 0, 3, 2'b00, 0, 0, 0,    0, 0, 0, 0, 1, 0, 16'h0000, 16'h0084);
    step("pick1",   0, 1, 1, 2'b00, 0, 0, 0,    0, 0, 0, 0, 0, 0, 16'h0002, 16'h0084);
    step("pick5",   0, 1, 5, 2'b00, 0, 0, 0,    0, 0, 0, 0, 0, 0, 16'h0022, 16'h0084);
    step("miss15",  0, 0, 3, 2'b01, 0, 1, 5,    0, 1, 0, 0, 0, 0, 16'h0022, 16'h0084);
    step("hold1",   0, 1, 3, 2'b00, 0, 0, 0,    0, 1, 0, 0, 0, 0, 16'h0022, 16'h0084);
    step("hold2",   0, 1, 4, 2'b00, 0, 0, 0,    0, 1, 0, 0, 0, 0, 16'h0022, 16'h0084);
    step("hold3",   0, 0, 4, 2'b00, 0, 0, 0,    0, 1, 0, 0, 0, 0, 16'h0022, 16'h0084);
    step("release", 0, 0, 3, 2'b00, 0, 0, 0,    1, 0, 0, 0, 1, 0, 16'h0000, 16'h0084);
    step("xhold1",  0, 1, 4, 2'b01, 1, 3, 3,    1, 0, 0, 0, 1, 0, 16'h0000, 16'h008C);
    step("xhold2",  0, 0, 3, 2'b01, 1, 3, 3,    1, 0, 0, 0, 0, 0, 16'h0000, 16'h008C);
    step("xhold3",  0, 0, 4, 2'b01, 1, 4, 4,    1, 0, 0, 0, 1, 0, 16'h0000, 16'h008C);
    step("xdrop",   0, 0, 4, 2'b00, 0, 0, 0,    1, 0, 0, 0, 1, 0, 16'h0000, 16'h008C);
    step("oor_idx", 0, 0, 9, 2'b01, 1, 9, 200,  1, 0, 0, 0, 0, 0, 16'h0000, 16'h028C);
    step("idle1",   0, 0, 9, 2'b00, 0, 0, 0,    1, 0, 0, 0, 0, 0, 16'h0000, 16'h028C);
    step("pick0",   0, 1, 0, 2'b00, 0, 0, 0,    1, 0, 0, 0, 0, 0, 16'h0001, 16'h028C);
    step("pick6",   0, 1, 6, 2'b00, 0, 0, 0,    1, 0, 0, 0, 0, 0, 16'h0041, 16'h028C);
    step("miss06",  0, 0, 6, 2'b01, 0, 0, 6,    1, 1, 0, 0, 0, 0, 16'h0041, 16'h028C);
    step("tie",     0, 0, 6, 2'b11, 0, 0, 0,    1, 0, 1, 1, 0, 0, 16'h0041, 16'h028C);
    step("done_sel",0, 1, 10,2'b00, 0, 0, 0,    1, 0, 1, 1, 0, 0, 16'h0041, 16'h028C);
    step("done_ev", 0, 1, 10,2'b01, 1, 10,11,   1, 0, 1, 1, 0, 0, 16'h0041, 16'h028C);
    step("done_x10",0, 0, 10,2'b10, 0, 0, 0,    1, 0, 1, 1, 0, 0, 16'h0041, 16'h028C);
    step("rst_done",1, 0, 3, 2'b00, 0, 0, 0,    0, 0, 0, 0, 1, 0, 16'h0000, 16'h0000);
    step("won",     0, 0, 3, 2'b10, 0, 0, 0,    0, 0, 1, 0, 0, 0, 16'h0000, 16'h0000);
    step("rst_won", 1, 0, 3, 2'b00, 0, 0, 0,    0, 0, 0, 0, 1, 0, 16'h0000, 16'h0000);
    step("pick5b",  0, 1, 5, 2'b00, 0, 0, 0,    0, 0, 0, 0, 0, 0, 16'h0020, 16'h0000);

    for (int k = 1; k <= 9; k++) begin
      tfu = 16'h0020; tp = 1'b0; tto = 1'b0;
`ifdef TURN_TIMEOUT_EN
      if (k >= 8) begin
        tfu = 16'h0000;
        tp  = 1'b1;
        tto = (k == 8);
      end
`endif
      step($sformatf("idle_to%0d", k), 0, 0, 5, 2'b00, 0, 0, 0,
           tp, 0, 0, 0, (tfu == 16'h0000), tto, tfu, 16'h0000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
